// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
//   state_e   : sequencer state encoding (2'b11 is unused and recovers to idle)
//   cnt_width : bit counter width, never below one bit
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle of the serial adder.
//   master : drives start/sub/a/b/cin, observes busy/done/sum/carry/overflow
//   slave  : the adder side of the same signals
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, carry, overflow
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: processes WIDTH-bit operands LSB-first, one bit per clock,
// through a single full_adder cell and a carry flip-flop.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of serial_adder_if (start/sub/a/b/cin in; busy/done/sum/carry/overflow out)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int unsigned      CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] opa_q;    // operand A out of bit 0, result bits in at the MSB
  logic [WIDTH-1:0] opb_q;    // operand B, pre-inverted for subtraction
  logic             c_q;      // carry into the bit currently being processed
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] opa_shift;
  logic [WIDTH-1:0] opb_shift;

  full_adder u_full_adder (
    .a_i (opa_q[0]),
    .b_i (opb_q[0]),
    .c_i (c_q),
    .s_o (fa_s),
    .c_o (fa_co)
  );

  // As operand A shifts out of bit 0, sum bits shift in from the MSB; after WIDTH
  // steps the register holds the complete result, so it doubles as the result shifter.
  if (WIDTH == 1) begin : g_shift_w1
    assign opa_shift = fa_s;
    assign opb_shift = 1'b0;
  end else begin : g_shift_wn
    assign opa_shift = {fa_s, opa_q[WIDTH-1:1]};
    assign opb_shift = {1'b0, opb_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            opa_q   <= bus.a;
            opb_q   <= bus.b ^ {WIDTH{bus.sub}};
            // Subtraction is a + ~b + 1.
            c_q     <= bus.sub | bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          opa_q <= opa_shift;
          opb_q <= opb_shift;
          c_q   <= fa_co;
          if (cnt_q == CntLast) begin
            sum_q   <= opa_shift;
            carry_q <= fa_co;
            // c_q is the carry into the MSB during the last step.
            ovf_q   <= c_q ^ fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases, handshake corner cases,
// randomized operations against an arithmetic reference model, and asynchronous reset abort.
module tb_serial_adder;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [7:0] last_sum;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {overflow, carry, sum} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    int ua, ub, sa, sb, r;
    logic c;
    logic [7:0] s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      c = (ua >= ub);
      s = 8'(ua - ub);
      r = sa - sb;
    end else begin
      c = (ua + ub + int'(cin)) > 255;
      s = 8'(ua + ub + int'(cin));
      r = sa + sb + int'(cin);
    end
    return {(r > 127) || (r < -128), c, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.sub   = sub;
  endtask

  // Follows one operation from its accepting edge to the DONE cycle. With hold set,
  // start stays high and operands are scrambled during RUN (they must be ignored).
  task automatic track(input logic [9:0] exp, input bit hold);
    logic [7:0] held;
    held = last_sum;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    check("busy_first", 32'(bus.busy), 32'd1);
    check("done_first", 32'(bus.done), 32'd0);
    for (int i = 1; i < 8; i++) begin
      if (hold) begin
        bus.a   = 8'($urandom);
        bus.b   = 8'($urandom);
        bus.sub = 1'($urandom);
        bus.cin = 1'($urandom);
      end
      @(posedge clk); #1;
      check("busy_run", 32'(bus.busy), 32'd1);
      check("done_run", 32'(bus.done), 32'd0);
      check("sum_held", 32'(bus.sum), 32'(held));
    end
    @(posedge clk); #1;
    check("busy_done", 32'(bus.busy), 32'd0);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("sum", 32'(bus.sum), 32'(exp[7:0]));
    check("carry", 32'(bus.carry), 32'(exp[8]));
    check("overflow", 32'(bus.overflow), 32'(exp[9]));
    last_sum = exp[7:0];
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                    input logic sub);
    @(negedge clk);
    drive(a, b, cin, sub);
    track(model(a, b, cin, sub), 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_sum    = 8'h00;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.sub     = 1'b0;
    bus.cin     = 1'b0;
    bus.a       = 8'h00;
    bus.b       = 8'h00;

    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_carry", 32'(bus.carry), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle with start low: nothing happens.
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_done", 32'(bus.done), 32'd0);

    // Directed arithmetic cases.
    op(8'h5A, 8'h33, 1'b0, 1'b0);
    check("case1_sum_const", 32'(bus.sum), 32'h8D);
    op(8'hFF, 8'h01, 1'b0, 1'b0);
    op(8'h7F, 8'h00, 1'b1, 1'b0);
    op(8'h10, 8'h20, 1'b0, 1'b1);
    op(8'h80, 8'h01, 1'b1, 1'b1);  // cin ignored in subtract mode
    check("sub_ovf_const", 32'(bus.overflow), 32'd1);

    // start held through RUN with changing operands, then back-to-back from DONE.
    @(negedge clk);
    drive(8'h5A, 8'h33, 1'b0, 1'b0);
    track(model(8'h5A, 8'h33, 1'b0, 1'b0), 1'b1);
    drive(8'h01, 8'h01, 1'b0, 1'b0);
    track(model(8'h01, 8'h01, 1'b0, 1'b0), 1'b0);
    check("b2b_sum_const", 32'(bus.sum), 32'h02);

    // Randomized operations, a few of them back-to-back.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] ra, rb;
      logic rc, rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (n % 4 == 3) begin
        drive(ra, rb, rc, rs);
        track(model(ra, rb, rc, rs), 1'b0);
      end else begin
        op(ra, rb, rc, rs);
      end
    end

    // Make sure the held result is non-zero so the reset clear is visible.
    op(8'h12, 8'h34, 1'b0, 1'b0);

    // Asynchronous reset during the 4th RUN cycle.
    @(negedge clk);
    drive(8'hC3, 8'h5C, 1'b1, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_carry", 32'(bus.carry), 32'd0);
    check("abort_ovf", 32'(bus.overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_sum = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("post_abort_done", 32'(bus.done), 32'd0);
      check("post_abort_sum", 32'(bus.sum), 32'd0);
    end

    // Recovery after the abort.
    op(8'hC3, 8'h5C, 1'b1, 1'b0);
    op(8'h00, 8'h01, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
